// File: rtl/pe_pkg.sv
// Shared types, default widths and the signed product helper for the
// zero-skipping MAC controller and its accumulator.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_PSUM_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 12;

  // Full-precision signed product, sign-extended to the accumulator width.
  function automatic logic [DEF_PSUM_WIDTH-1:0] sext_prod(
    input logic signed [DEF_DATA_WIDTH-1:0] a,
    input logic signed [DEF_DATA_WIDTH-1:0] b
  );
    logic signed [2*DEF_DATA_WIDTH-1:0] p;
    p = (2*DEF_DATA_WIDTH)'(a) * (2*DEF_DATA_WIDTH)'(b);
    return DEF_PSUM_WIDTH'(p);
  endfunction

endpackage

// File: rtl/psum_accumulator.sv
// Operand-gated signed multiply-accumulate register. The next value is
// exported so the controller can capture the final psum in the same edge.
module psum_accumulator
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  en_i,
  input  logic                  gate_i,
  input  logic [PSUM_WIDTH-1:0] init_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [PSUM_WIDTH-1:0] acc_next_o
);

  logic signed [DATA_WIDTH-1:0] a_g;
  logic signed [DATA_WIDTH-1:0] b_g;
  logic        [PSUM_WIDTH-1:0] acc_q;
  logic        [PSUM_WIDTH-1:0] acc_d;

  // A skipped tap holds the multiplier inputs at zero so nothing toggles.
  assign a_g = gate_i ? '0 : $signed(a_i);
  assign b_g = gate_i ? '0 : $signed(b_i);

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = init_i;
    end else if (en_i && !gate_i) begin
      acc_d = acc_q + sext_prod(a_g, b_g);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/zero_skip_mac_ctrl.sv
// Walks filter taps per start pulse, accumulating ifmap x filter products
// while skipping taps flagged zero, then reports psum, skip count and shift.
module zero_skip_mac_ctrl
  import pe_pkg::*;
#(
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  filter_len,
  input  logic                  shift_en,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  zero_flag,
  input  logic [DATA_WIDTH-1:0] ifmap_data,
  input  logic [DATA_WIDTH-1:0] filt_data,
  output logic [PSUM_WIDTH-1:0] psum_out,
  output logic                  psum_valid,
  output logic [CNT_WIDTH-1:0]  skip_count,
  output logic                  shift,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(MEM_DEPTH);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [CNT_WIDTH-1:0]    len_q;
  logic [CNT_WIDTH-1:0]    skips_q;
  logic [CNT_WIDTH-1:0]    skips_d;
  logic [CNT_WIDTH-1:0]    len_clamp;
  logic                    sh_q;
  logic                    last_tap;
  logic [PSUM_WIDTH-1:0]   psum_out_q;
  logic [CNT_WIDTH-1:0]    skip_count_q;
  logic                    psum_valid_q;
  logic                    shift_q;
  logic                    busy_q;
  logic                    acc_load;
  logic [PSUM_WIDTH-1:0]   acc_next;

  assign len_clamp = (filter_len > MAX_LEN) ? MAX_LEN : filter_len;
  assign skips_d   = skips_q + CNT_WIDTH'(zero_flag);
  assign last_tap  = (CNT_WIDTH'(idx_q) == (len_q - CNT_WIDTH'(1)));
  assign acc_load  = (state_q == IDLE) && start;

  psum_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .PSUM_WIDTH (PSUM_WIDTH)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .load_i     (acc_load),
    .en_i       (state_q == RUN),
    .gate_i     (zero_flag),
    .init_i     (psum_in),
    .a_i        (ifmap_data),
    .b_i        (filt_data),
    .acc_next_o (acc_next)
  );

  // Results are captured on the edge entering DONE so they coincide with psum_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      skips_q      <= '0;
      sh_q         <= 1'b0;
      psum_out_q   <= '0;
      skip_count_q <= '0;
      psum_valid_q <= 1'b0;
      shift_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      psum_valid_q <= 1'b0;
      shift_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            len_q   <= len_clamp;
            sh_q    <= shift_en;
            idx_q   <= '0;
            skips_q <= '0;
            busy_q  <= 1'b1;
            if (len_clamp == '0) begin
              state_q      <= DONE;
              psum_out_q   <= psum_in;
              skip_count_q <= '0;
              psum_valid_q <= 1'b1;
              shift_q      <= shift_en;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          skips_q <= skips_d;
          if (last_tap) begin
            state_q      <= DONE;
            psum_out_q   <= acc_next;
            skip_count_q <= skips_d;
            psum_valid_q <= 1'b1;
            shift_q      <= sh_q;
          end else begin
            idx_q <= idx_q + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign r_addr     = (state_q == RUN) ? idx_q : '0;
  assign psum_out   = psum_out_q;
  assign psum_valid = psum_valid_q;
  assign skip_count = skip_count_q;
  assign shift      = shift_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_zero_skip_mac_ctrl.sv
// Directed bench for zero_skip_mac_ctrl: hand-computed psums, latencies,
// skip counts, shift pulses, length clamp, mid-run reset and signed wrap.
module tb_zero_skip_mac_ctrl;
  import pe_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  filter_len;
  logic        shift_en;
  logic [31:0] psum_in;
  logic [3:0]  r_addr;
  logic        zero_flag;
  logic [15:0] ifmap_data;
  logic [15:0] filt_data;
  logic [31:0] psum_out;
  logic        psum_valid;
  logic [3:0]  skip_count;
  logic        shift;
  logic        busy;
  state_t      dbg_state;

  logic [15:0] ifm [12];
  logic [15:0] flt [12];
  logic        flg [12];

  int checks = 0;
  int errors = 0;

  int          r_lat;
  logic [31:0] r_psum;
  logic [3:0]  r_skip;
  int          r_shifts;
  int          r_valids;
  int          r_busy;
  int          r_maxaddr;

  zero_skip_mac_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .filter_len (filter_len),
    .shift_en   (shift_en),
    .psum_in    (psum_in),
    .r_addr     (r_addr),
    .zero_flag  (zero_flag),
    .ifmap_data (ifmap_data),
    .filt_data  (filt_data),
    .psum_out   (psum_out),
    .psum_valid (psum_valid),
    .skip_count (skip_count),
    .shift      (shift),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Spad and flag-buffer models: combinational read at r_addr.
  assign ifmap_data = (r_addr < 4'd12) ? ifm[r_addr] : 16'hDEAD;
  assign filt_data  = (r_addr < 4'd12) ? flt[r_addr] : 16'hDEAD;
  assign zero_flag  = (r_addr < 4'd12) ? flg[r_addr] : 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_taps();
    for (int i = 0; i < 12; i++) begin
      ifm[i] = 16'd0;
      flt[i] = 16'd0;
      flg[i] = 1'b0;
    end
  endtask

  task automatic set_tap(input int i, input logic [15:0] a, input logic [15:0] b, input logic f);
    ifm[i] = a;
    flt[i] = b;
    flg[i] = f;
  endtask

  // Pulses start for one cycle, then watches until one cycle past psum_valid.
  task automatic run_job(input logic [31:0] p_in, input logic [3:0] len, input logic sh);
    r_lat = 0; r_shifts = 0; r_valids = 0; r_busy = 0; r_maxaddr = 0;
    r_psum = 32'hx; r_skip = 4'hx;
    @(negedge clk);
    psum_in = p_in; filter_len = len; shift_en = sh; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (shift) r_shifts++;
      if (psum_valid) r_valids++;
      if (busy) r_busy++;
      if (int'(r_addr) > r_maxaddr) r_maxaddr = int'(r_addr);
      if (psum_valid && r_lat == 0) begin
        r_lat  = c;
        r_psum = psum_out;
        r_skip = skip_count;
      end else if (r_lat != 0) begin
        break;
      end
    end
  endtask

  initial begin
    int v1, v2;
    reset = 1'b0; start = 1'b0; filter_len = '0; shift_en = 1'b0; psum_in = '0;
    clear_taps();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psum", psum_out, 32'd0);
    check("rst_valid", {31'd0, psum_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    reset = 1'b1;

    // 1: plain accumulate
    clear_taps();
    set_tap(0, 16'd2, 16'd1, 1'b0);
    set_tap(1, 16'd3, 16'd1, 1'b0);
    set_tap(2, 16'd4, 16'd1, 1'b0);
    run_job(32'd10, 4'd3, 1'b0);
    check("t1_psum", r_psum, 32'd19);
    check("t1_skip", {28'd0, r_skip}, 32'd0);
    check("t1_lat", r_lat, 32'd4);
    check("t1_shift", r_shifts, 32'd0);
    check("t1_valids", r_valids, 32'd1);
    check("t1_busy", r_busy, 32'd4);
    check("t1_maxaddr", r_maxaddr, 32'd2);

    // 2: zero skipping
    clear_taps();
    set_tap(0, 16'd0, 16'd7, 1'b1);
    set_tap(1, 16'd5, 16'd3, 1'b0);
    set_tap(2, 16'd0, 16'd9, 1'b1);
    set_tap(3, -16'sd2, 16'd4, 1'b0);
    run_job(32'd0, 4'd4, 1'b0);
    check("t2_psum", r_psum, 32'd7);
    check("t2_skip", {28'd0, r_skip}, 32'd2);
    check("t2_lat", r_lat, 32'd5);

    // 3: zero-length pass-through with shift
    run_job(32'h1234, 4'd0, 1'b1);
    check("t3_psum", r_psum, 32'h1234);
    check("t3_lat", r_lat, 32'd1);
    check("t3_skip", {28'd0, r_skip}, 32'd0);
    check("t3_shift", r_shifts, 32'd1);
    check("t3_maxaddr", r_maxaddr, 32'd0);
    check("t3_busy", r_busy, 32'd1);

    // 4: length clamp to 12 taps
    for (int i = 0; i < 12; i++) set_tap(i, 16'd1, 16'd1, 1'b0);
    run_job(32'd100, 4'd15, 1'b1);
    check("t4_psum", r_psum, 32'd112);
    check("t4_maxaddr", r_maxaddr, 32'd11);
    check("t4_lat", r_lat, 32'd13);
    check("t4_shift", r_shifts, 32'd1);

    // flagged tap with non-zero data must not contribute
    clear_taps();
    set_tap(0, 16'd9, 16'd9, 1'b1);
    set_tap(1, 16'd1, 16'd1, 1'b0);
    run_job(32'd0, 4'd2, 1'b0);
    check("gate_psum", r_psum, 32'd1);
    check("gate_skip", {28'd0, r_skip}, 32'd1);

    // 5: reset in RUN cycle 2 of a len=6 run
    for (int i = 0; i < 12; i++) set_tap(i, 16'd1, 16'd1, (i == 0));
    @(negedge clk);
    psum_in = 32'd50; filter_len = 4'd6; shift_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_psum", psum_out, 32'd0);
    check("t5_skip", {28'd0, skip_count}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_raddr", {28'd0, r_addr}, 32'd0);
    reset = 1'b1;
    r_valids = 0; r_shifts = 0;
    repeat (8) begin
      @(negedge clk);
      if (psum_valid) r_valids++;
      if (shift) r_shifts++;
    end
    check("t5_no_valid", r_valids, 32'd0);
    check("t5_no_shift", r_shifts, 32'd0);
    clear_taps();
    set_tap(0, 16'd2, 16'd1, 1'b0);
    set_tap(1, 16'd3, 16'd1, 1'b0);
    set_tap(2, 16'd4, 16'd1, 1'b0);
    run_job(32'd10, 4'd3, 1'b0);
    check("t5_rerun_psum", r_psum, 32'd19);
    check("t5_rerun_lat", r_lat, 32'd4);

    // back-to-back with start held high: period len+2
    v1 = 0; v2 = 0;
    @(negedge clk);
    psum_in = 32'd10; filter_len = 4'd3; shift_en = 1'b0; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (psum_valid) begin
        if (v1 == 0) v1 = c;
        else begin
          v2 = c;
          check("b2b_psum", psum_out, 32'd19);
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_period", v2 - v1, 32'd5);
    repeat (3) @(negedge clk);

    // 6: signed wrap and most-negative operands
    clear_taps();
    set_tap(0, 16'd1, 16'd1, 1'b0);
    run_job(32'h7FFF_FFFF, 4'd1, 1'b0);
    check("t6_wrap", r_psum, 32'h8000_0000);
    set_tap(0, 16'h8000, 16'h8000, 1'b0);
    run_job(32'd5, 4'd1, 1'b0);
    check("t6_minsq", r_psum, 32'h4000_0005);
    set_tap(0, 16'h8000, 16'd3, 1'b0);
    run_job(32'd0, 4'd1, 1'b0);
    check("t6_neg", r_psum, 32'hFFFE_8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zero_skip_mac_ctrl.md
Name: zero_skip_mac_ctrl

Overview:
- Downstream consumer of the PE ifmap zero-skipping flag buffer.
- Per start pulse, walks filter taps 0..filter_len-1 and drives the shared read address to the ifmap spad, filter spad and zero-flag buffer.
- Accumulates signed ifmap×filter products into a psum, skipping (operand-gating) every tap whose zero_flag is 1.
- Emits the finished psum, a skip count, and a one-cycle window-shift request back to the ifmap/zero-flag buffers.

Parameters:
- MEM_DEPTH, 12, ifmap/filter spad depth (max taps per run).
- DATA_WIDTH, 16, signed ifmap and filter operand width.
- PSUM_WIDTH, 32, signed accumulator width.
- ADDR_WIDTH, $clog2(MEM_DEPTH), tap address width.
- CNT_WIDTH, $clog2(MEM_DEPTH+1), tap-length and skip-count width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low reset.
- start, input, 1, begin one accumulation run; sampled only in IDLE.
- filter_len, input, CNT_WIDTH, number of taps for this run; latched at start.
- shift_en, input, 1, latched at start; if 1, a shift request is issued at end of run.
- psum_in, input, PSUM_WIDTH, initial accumulator value; latched at start.
- r_addr, output, ADDR_WIDTH, current tap address to ifmap spad, filter spad and zero-flag buffer.
- zero_flag, input, 1, 1 = ifmap at r_addr is zero; combinational return for r_addr.
- ifmap_data, input, DATA_WIDTH, ifmap word at r_addr; combinational.
- filt_data, input, DATA_WIDTH, filter word at r_addr; combinational.
- psum_out, output, PSUM_WIDTH, result of last run; held until the next DONE.
- psum_valid, output, 1, one-cycle pulse when psum_out updates.
- skip_count, output, CNT_WIDTH, taps skipped in last run; updates with psum_out.
- shift, output, 1, one-cycle window-shift request to upstream buffers.
- busy, output, 1, high in RUN and DONE.

Behaviour:
- Reset (reset==0 at posedge) takes priority over everything, including mid-run:
  - state=IDLE, acc=0, idx=0, skip counter=0.
  - psum_out=0, skip_count=0, psum_valid=0, shift=0, busy=0, r_addr=0.
  - No partial psum_out or shift is emitted for an aborted run.
- States: IDLE, RUN, DONE.
- IDLE:
  - r_addr=0.
  - On start=1: acc<=psum_in; len<=min(filter_len, MEM_DEPTH); sh<=shift_en; idx<=0; skips<=0.
  - If the clamped len==0, go to DONE (psum passes through unchanged). Otherwise go to RUN.
  - start is ignored outside IDLE.
- RUN, one tap per cycle:
  - r_addr=idx.
  - If zero_flag=1: acc unchanged, skips<=skips+1, multiplier operands forced to 0.
  - Else: acc<=acc+sext(ifmap_data×filt_data), signed, 2×DATA_WIDTH product sign-extended to PSUM_WIDTH, wrap modulo 2^PSUM_WIDTH with no saturation.
  - If idx==len-1, go to DONE. Otherwise idx<=idx+1.
- DONE, one cycle:
  - psum_out<=acc; skip_count<=skips; psum_valid=1.
  - shift=sh, so shift is high for exactly this one cycle.
  - Next state is IDLE.
  - The flag buffer shifts on the following falling edge; r_addr is 0 in IDLE afterwards.
- Latency: start accepted at cycle 0; psum_valid at cycle len+1; next start can be accepted in the cycle after DONE.
- Back-to-back: start held high re-triggers in the first IDLE cycle, giving a period of len+2 cycles.
- All outputs are registered except r_addr, which is decoded from state/idx.

Decomposition:
- Package pe_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - Default widths DATA_WIDTH=16, PSUM_WIDTH=32, MEM_DEPTH=12.
  - Function sext_prod(a, b) returning the sign-extended product.
- One sub-module: psum_accumulator.
  - Gated signed multiply + PSUM_WIDTH adder + acc register with load/enable.
  - Instantiated once. The FSM, idx and skip counters stay in zero_skip_mac_ctrl.

Test Plan:
1. psum_in=10, len=3, ifmap={2,3,4}, filt={1,1,1}, flags=0 → psum_out=19, skip_count=0, psum_valid at cycle 4, shift=0 (shift_en=0).
2. len=4, ifmap={0,5,0,-2}, filt={7,3,9,4}, flags={1,0,1,0}, psum_in=0 → psum_out=7, skip_count=2; no accumulator change on skipped cycles.
3. len=0, psum_in=0x1234, shift_en=1 → psum_out=0x1234 one cycle after start, skip_count=0, shift pulses once, r_addr never leaves 0.
4. filter_len=15 (>MEM_DEPTH), all ifmap=1, filt=1 → r_addr sweeps 0..11 only, psum_out=psum_in+12.
5. reset low at RUN cycle 2 of a len=6 run → all outputs 0 next cycle; no psum_valid or shift; a subsequent run produces a correct result.
6. Signed wrap: psum_in=0x7FFFFFFF, ifmap=1, filt=1, len=1 → psum_out=0x80000000. Also ifmap=-32768, filt=-32768 → product +2^30 accumulated correctly.
